// File: rtl/ram_logger_pkg.sv
// Shared definitions for the RAM event logger.
//   state_t   : write-master FSM states
//   BE_ALL    : byte enables for a full-word write
//   next_head : advance a log offset with wrap at the region length
package ram_logger_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic [31:0] next_head(input logic [31:0] ofs, input logic [31:0] len);
        return (ofs + 32'd1 >= len) ? 32'd0 : ofs + 32'd1;
    endfunction

endpackage

// File: rtl/ram_logger_fifo.sv
// Show-ahead synchronous FIFO buffering event words for the log writer.
//   clk, reset_n : clock, async active-low reset (pointers only)
//   push / din   : write strobe and data; caller guarantees not full unless popping
//   pop          : remove head entry
//   dout         : current head entry
//   dout_next    : entry that becomes the head after a pop this cycle
//                  (falls through to din when only one entry is stored)
//   single       : exactly one entry stored
//   full, empty  : occupancy flags
module ram_logger_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] dout_next,
    output logic              single,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [PTR_W:0]    count;

    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
    assign dout       = mem[rd_ptr];
    assign single     = (count == (PTR_W+1)'(1));
    assign dout_next  = single ? din : mem[rd_ptr_nxt];
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_event_logger.sv
// Avalon-MM write master that logs event words into a circular RAM region.
//
// state | meaning
// IDLE  | no transfer outstanding; waiting for a buffered event
// WRITE | cs asserted; holding address/data until the slave accepts
//
//   clk, reset_n          : clock, async active-low reset
//   evt_valid, evt_data   : event strobe and word (no backpressure)
//   log_clear             : restart the log at LOG_BASE, clear wrap flag and drop count
//   m_*                   : Avalon-MM write master to the RAM slave
//   head_ofs, wrapped     : next write offset and sticky wrap flag
//   drop_count            : saturating count of events lost to a full FIFO
//   busy                  : FIFO non-empty or transfer outstanding
module ram_event_logger
    import ram_logger_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] LOG_BASE   = 12'h800,
    parameter int                LOG_LEN    = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              evt_valid,
    input  logic [DATA_W-1:0] evt_data,
    input  logic              log_clear,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    output logic [ADDR_W-1:0] head_ofs,
    output logic              wrapped,
    output logic [15:0]       drop_count,
    output logic              busy
);
    state_t            state, state_d;
    logic              cs_d;
    logic [ADDR_W-1:0] addr_d, head_d, head_adv;
    logic [DATA_W-1:0] data_d;
    logic              wrapped_d;
    logic              clear_pend, clear_pend_d;

    logic              done, push, drop, more;
    logic [DATA_W-1:0] fifo_dout, fifo_dout_next;
    logic              fifo_single, fifo_full, fifo_empty;

    assign done = m_chipselect & ~m_waitrequest;
    // A full FIFO still accepts the event when the head is leaving this cycle.
    assign push = evt_valid & (~fifo_full | done);
    assign drop = evt_valid & ~push;
    // Entries remaining after the completing word is popped.
    assign more = ~fifo_single | push;

    ram_logger_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (done),
        .din       (evt_data),
        .dout      (fifo_dout),
        .dout_next (fifo_dout_next),
        .single    (fifo_single),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_adv     = ADDR_W'(next_head(32'(head_ofs), 32'(LOG_LEN)));
    assign m_write      = m_chipselect;
    assign m_byteenable = m_chipselect ? BE_ALL : 4'b0000;
    assign busy         = ~fifo_empty | m_chipselect;

    always_comb begin
        state_d      = state;
        cs_d         = m_chipselect;
        addr_d       = m_address;
        data_d       = m_writedata;
        head_d       = head_ofs;
        wrapped_d    = wrapped;
        clear_pend_d = clear_pend;
        case (state)
            IDLE: begin
                if (log_clear) begin
                    head_d    = '0;
                    wrapped_d = 1'b0;
                end
                if (!fifo_empty) begin
                    state_d = WRITE;
                    cs_d    = 1'b1;
                    data_d  = fifo_dout;
                    addr_d  = LOG_BASE + head_d;
                end
            end
            WRITE: begin
                if (done) begin
                    // A clear seen during the transfer lands here and beats the increment.
                    if (log_clear || clear_pend) begin
                        head_d    = '0;
                        wrapped_d = 1'b0;
                    end else begin
                        head_d = head_adv;
                        if (head_ofs == ADDR_W'(LOG_LEN - 1)) wrapped_d = 1'b1;
                    end
                    clear_pend_d = 1'b0;
                    if (more) begin
                        data_d = fifo_dout_next;
                        addr_d = LOG_BASE + head_d;
                    end else begin
                        state_d = IDLE;
                        cs_d    = 1'b0;
                    end
                end else if (log_clear) begin
                    clear_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            m_chipselect <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            head_ofs     <= '0;
            wrapped      <= 1'b0;
            clear_pend   <= 1'b0;
        end else begin
            state        <= state_d;
            m_chipselect <= cs_d;
            m_address    <= addr_d;
            m_writedata  <= data_d;
            head_ofs     <= head_d;
            wrapped      <= wrapped_d;
            clear_pend   <= clear_pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (log_clear) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ram_event_logger.sv
module tb_ram_event_logger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        evt_valid = 1'b0;
    logic [31:0] evt_data = '0;
    logic        log_clear = 1'b0;
    logic        m_waitrequest = 1'b0;
    logic [11:0] m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic [11:0] head_ofs;
    logic        wrapped;
    logic [15:0] drop_count;
    logic        busy;

    ram_event_logger #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .LOG_BASE   (12'h800),
        .LOG_LEN    (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .log_clear     (log_clear),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .head_ofs      (head_ofs),
        .wrapped       (wrapped),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [31:0] data;
        int          stall;
        logic [11:0] addr;
        logic [11:0] head;
        logic        wrap;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string name, input logic [11:0] addr, input logic [31:0] data);
        wr_t w;
        total++;
        if (wq.size() == 0) begin
            bad++;
            $display("FAIL %s: got no write expected addr %h data %h", name, addr, data);
        end else begin
            w = wq.pop_front();
            chk({name, " addr"}, 32'(w.addr), 32'(addr));
            chk({name, " data"}, w.data, data);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("idle timeout", 32'(busy), 32'd0);
    endtask

    // Bus monitor: records completed writes and checks hold stability under stall.
    logic        prev_ok = 1'b0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_chipselect) begin
                chk("m_write", 32'(m_write), 32'd1);
                chk("m_byteenable", 32'(m_byteenable), 32'hF);
            end else begin
                chk("m_write idle", 32'(m_write), 32'd0);
                chk("m_byteenable idle", 32'(m_byteenable), 32'd0);
            end
            if (prev_ok && prev_stall) begin
                chk("stall cs", 32'(m_chipselect), 32'd1);
                chk("stall addr", 32'(m_address), 32'(prev_addr));
                chk("stall data", m_writedata, prev_data);
            end
            if (m_chipselect && !m_waitrequest) wq.push_back('{addr: m_address, data: m_writedata});
            prev_stall = m_chipselect && m_waitrequest;
            prev_addr  = m_address;
            prev_data  = m_writedata;
            prev_ok    = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{data: 32'hCAFE0001, stall: 0, addr: 12'h800, head: 12'd1, wrap: 1'b0};
        vecs[1] = '{data: 32'h11110002, stall: 5, addr: 12'h801, head: 12'd2, wrap: 1'b0};
        vecs[2] = '{data: 32'h22220003, stall: 0, addr: 12'h802, head: 12'd3, wrap: 1'b0};
        vecs[3] = '{data: 32'h33330004, stall: 2, addr: 12'h803, head: 12'd0, wrap: 1'b1};
        vecs[4] = '{data: 32'h44440005, stall: 0, addr: 12'h800, head: 12'd1, wrap: 1'b1};
        vecs[5] = '{data: 32'h55550006, stall: 1, addr: 12'h801, head: 12'd2, wrap: 1'b1};

        // Reset values
        #12;
        chk("rst cs", 32'(m_chipselect), 32'd0);
        chk("rst addr", 32'(m_address), 32'd0);
        chk("rst data", m_writedata, 32'd0);
        chk("rst be", 32'(m_byteenable), 32'd0);
        chk("rst head", 32'(head_ofs), 32'd0);
        chk("rst wrapped", 32'(wrapped), 32'd0);
        chk("rst drop", 32'(drop_count), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        #5 reset_n = 1'b1;
        tick();

        // Single events, stalls and wrap from a table
        for (int i = 0; i < 6; i++) begin
            evt_data      = vecs[i].data;
            evt_valid     = 1'b1;
            m_waitrequest = 1'b0;
            tick();
            evt_valid = 1'b0;
            chk("N+1 busy", 32'(busy), 32'd1);
            chk("N+1 cs", 32'(m_chipselect), 32'd0);
            tick();
            chk("N+2 cs", 32'(m_chipselect), 32'd1);
            chk("N+2 addr", 32'(m_address), 32'(vecs[i].addr));
            chk("N+2 data", m_writedata, vecs[i].data);
            m_waitrequest = (vecs[i].stall > 0);
            for (int k = 0; k < vecs[i].stall; k++) tick();
            m_waitrequest = 1'b0;
            tick();
            chk("done busy", 32'(busy), 32'd0);
            chk("done cs", 32'(m_chipselect), 32'd0);
            chk("vec head", 32'(head_ofs), 32'(vecs[i].head));
            chk("vec wrapped", 32'(wrapped), 32'(vecs[i].wrap));
            expect_write("vec write", vecs[i].addr, vecs[i].data);
            chk("vec write count", 32'(wq.size()), 32'd0);
        end

        // Clear in IDLE
        log_clear = 1'b1;
        tick();
        log_clear = 1'b0;
        chk("idle clear head", 32'(head_ofs), 32'd0);
        chk("idle clear wrapped", 32'(wrapped), 32'd0);

        // Overflow: 7 strobes under stall, 4 buffered, 3 dropped
        m_waitrequest = 1'b1;
        for (int i = 0; i < 7; i++) begin
            evt_valid = 1'b1;
            evt_data  = 32'hD0000000 + 32'(i);
            tick();
        end
        evt_valid = 1'b0;
        chk("ovf drop", 32'(drop_count), 32'd3);
        chk("ovf cs", 32'(m_chipselect), 32'd1);
        chk("ovf addr", 32'(m_address), 32'h800);
        chk("ovf data", m_writedata, 32'hD0000000);
        m_waitrequest = 1'b0;
        wait_idle(n);
        chk("ovf b2b cycles", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++)
            expect_write("ovf write", 12'h800 + 12'(i), 32'hD0000000 + 32'(i));
        chk("ovf extra writes", 32'(wq.size()), 32'd0);
        chk("ovf head", 32'(head_ofs), 32'd0);
        chk("ovf wrapped", 32'(wrapped), 32'd1);

        // Clear while the third write is stalled
        m_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            evt_valid = 1'b1;
            evt_data  = 32'hE0000000 + 32'(i);
            tick();
        end
        evt_valid = 1'b0;
        m_waitrequest = 1'b0;
        tick();
        tick();
        m_waitrequest = 1'b1;
        log_clear     = 1'b1;
        chk("clr addr", 32'(m_address), 32'h802);
        tick();
        log_clear = 1'b0;
        chk("clr deferred head", 32'(head_ofs), 32'd2);
        chk("clr held addr", 32'(m_address), 32'h802);
        chk("clr drop", 32'(drop_count), 32'd0);
        chk("clr wrapped held", 32'(wrapped), 32'd1);
        tick();
        m_waitrequest = 1'b0;
        tick();
        chk("clr head", 32'(head_ofs), 32'd0);
        chk("clr wrapped", 32'(wrapped), 32'd0);
        chk("clr next addr", 32'(m_address), 32'h800);
        wait_idle(n);
        expect_write("clr w0", 12'h800, 32'hE0000000);
        expect_write("clr w1", 12'h801, 32'hE0000001);
        expect_write("clr w2", 12'h802, 32'hE0000002);
        expect_write("clr w3", 12'h800, 32'hE0000003);
        chk("clr final head", 32'(head_ofs), 32'd1);

        // Async reset mid-WRITE
        m_waitrequest = 1'b1;
        evt_valid     = 1'b1;
        evt_data      = 32'hF0000001;
        tick();
        evt_data = 32'hF0000002;
        tick();
        evt_valid = 1'b0;
        chk("ar cs before", 32'(m_chipselect), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar cs async", 32'(m_chipselect), 32'd0);
        chk("ar busy", 32'(busy), 32'd0);
        #10 reset_n = 1'b1;
        m_waitrequest = 1'b0;
        tick();
        chk("ar addr", 32'(m_address), 32'd0);
        chk("ar data", m_writedata, 32'd0);
        chk("ar head", 32'(head_ofs), 32'd0);
        chk("ar wrapped", 32'(wrapped), 32'd0);
        chk("ar drop", 32'(drop_count), 32'd0);
        chk("ar busy after", 32'(busy), 32'd0);
        chk("ar no write", 32'(wq.size()), 32'd0);
        evt_valid = 1'b1;
        evt_data  = 32'h600D0001;
        tick();
        evt_valid = 1'b0;
        wait_idle(n);
        expect_write("ar new write", 12'h800, 32'h600D0001);
        chk("ar new head", 32'(head_ofs), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
